// File: rtl/mem_read_responder.sv
// Consumes the address-counter stream, issues BRAM reads and realigns the read data
// with valid/last tags across the memory latency, tracking frame completion or abort.
module mem_read_responder #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 512,
  parameter int READ_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  done,
  output logic                  aborted,
  output logic                  oob_err
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t              state;
  logic                in_range;
  logic                issue;
  logic                last_issue;
  logic                armed;
  logic                pipe_busy;
  logic                last_out;
  logic                last_seen;
  logic [READ_LAT:0]   vld_p;
  logic [READ_LAT:0]   last_p;

  assign in_range   = ({1'b0, addr} < DEPTH_EXT);
  assign issue      = en && in_range;
  assign last_issue = issue && (addr == LAST_ADDR);
  // Last tags are only armed for the frame that started from IDLE.
  assign armed      = (state == IDLE) || (state == STREAM);
  assign pipe_busy  = |vld_p;
  assign last_out   = last_seen || (out_valid && out_last);

  // Stage p0: issue to BRAM; tag pipeline walks alongside the read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en   <= 1'b0;
      mem_addr <= '0;
      vld_p    <= '0;
      last_p   <= '0;
      oob_err  <= 1'b0;
    end else begin
      mem_en <= issue;
      if (issue)
        mem_addr <= addr;
      vld_p  <= {vld_p[READ_LAT-1:0], issue};
      last_p <= {last_p[READ_LAT-1:0], last_issue && armed};
      if (en && !in_range)
        oob_err <= 1'b1;
    end
  end

  // Output stage: capture read data as its tag leaves the pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= vld_p[READ_LAT];
      out_last  <= vld_p[READ_LAT] && last_p[READ_LAT];
      if (vld_p[READ_LAT])
        out_data <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      done      <= 1'b0;
      aborted   <= 1'b0;
      last_seen <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          last_seen <= 1'b0;
          if (en)
            state <= last_issue ? DRAIN : STREAM;
        end
        STREAM: begin
          if (last_issue) begin
            state <= DRAIN;
          end else if (!en) begin
            aborted <= 1'b1;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_valid && out_last)
            last_seen <= 1'b1;
          // out_last may still be sitting in the output register on the empty cycle.
          if (!pipe_busy) begin
            if (last_out) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= IDLE;
            end
          end
        end
        DONE: begin
          last_seen <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_read_responder.md
Name: mem_read_responder

Overview:
- Sits at the consuming end of the address-counter interface. It accepts the per-cycle address stream qualified by `en` and issues reads to a synchronous BRAM port.
- It realigns BRAM read data with a valid/last sideband across the memory's fixed read latency and tracks frame state (stream, drain, done, abort).
- Downstream scoring logic (margin computation over the sample set) consumes `out_data`/`out_valid`/`out_last` with no backpressure.

Parameters:
ADDR_WIDTH, 13, width of incoming address and BRAM address
DATA_WIDTH, 32, width of BRAM read data and `out_data`
DEPTH, 512, number of valid entries per frame; last valid address = DEPTH-1
READ_LAT, 2, BRAM read latency in cycles (1..4)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  address stream qualifier; high = `addr` is valid this cycle
addr  input  ADDR_WIDTH  address from the counter; expected 0,1,2,... while `en` is high
mem_addr  output  ADDR_WIDTH  BRAM read address, registered
mem_en  output  1  BRAM read enable, registered
mem_rdata  input  DATA_WIDTH  BRAM read data, valid READ_LAT cycles after `mem_en`
out_data  output  DATA_WIDTH  read data to downstream, registered
out_valid  output  1  `out_data` valid this cycle
out_last  output  1  with `out_valid`: this word came from address DEPTH-1
done  output  1  one-cycle pulse after the last word of a complete frame is output
aborted  output  1  one-cycle pulse when `en` falls before address DEPTH-1 was issued
oob_err  output  1  sticky; set when `en`=1 with `addr` >= DEPTH; cleared only by reset

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM = IDLE; valid/last pipeline cleared.
- Issue stage:
  - When `en`=1 and `addr` < DEPTH: `mem_addr`<=`addr`, `mem_en`<=1 on the next edge.
  - Otherwise `mem_en`<=0 and `mem_addr` holds.
- Out-of-range:
  - `en`=1 with `addr` >= DEPTH sets `oob_err` and issues no read.
  - Otherwise ignored; no `out_valid` for that cycle.
- Alignment: a shift register of depth READ_LAT+1 carries {valid, last} from the issue stage. Total latency from `en`/`addr` sample to `out_valid` = READ_LAT+1 cycles (3 at default). `out_data` is registered from `mem_rdata` in the same cycle the pipeline valid reaches the output.
- Last: the tag is set when the issued address equals DEPTH-1.
- No stalls: one word per cycle sustained. Gaps in `en` produce matching gaps in `out_valid`.
- FSM:
  - IDLE: `en`=1 -> STREAM.
  - STREAM:
    - Issues address DEPTH-1 -> DRAIN.
    - `en` falls before DEPTH-1 issued -> pulse `aborted`, go to DRAIN without a last tag.
  - DRAIN: wait until the pipeline holds no valid.
    - If the last word was output -> DONE.
    - Else -> IDLE.
    - `en` high during DRAIN: addresses are still issued, but `out_last`/`done` are not re-armed until IDLE.
  - DONE: `done`=1 for exactly one cycle -> IDLE.
- In-flight reads always complete and are output, including after an abort.
- The counter restart (`en` low then high) starts a new frame from IDLE. `en` held high past DEPTH-1 yields addresses >= DEPTH, which set `oob_err` and are not read.
- Simultaneous: `done` and a new frame's first `en` in the same cycle: `done` pulses and the new frame is accepted on the following cycle (IDLE entered first).
- Reset mid-frame: pipeline dropped immediately, no `done`/`aborted` pulse, `oob_err` cleared.

Test Plan:
- Full frame: `en`=1 for 512 cycles, `addr` 0..511, BRAM model returns data=addr^0xA5A5 -> 512 consecutive `out_valid` starting 3 cycles after first `en`; `out_last` only on word 511; `done` pulse 1 cycle after `out_last`; `aborted`=0.
- Abort: `en` high for addr 0..99, then low -> `aborted` pulse the cycle after `en` falls; exactly 100 `out_valid` words; no `out_last`, no `done`; FSM back to IDLE.
- Gapped stream: `en` toggles 1,0,1,1,0 with `addr` 0,-,1,2,- -> `out_valid` pattern 1,0,1,1,0 delayed by 3 cycles; data matches addresses 0,1,2.
- Overrun: `en` held for 514 cycles (`addr` up to 513) -> 512 valid words; `oob_err` set at `addr`=512 and remains 1 after frame end until reset.
- Reset mid-frame: assert `rst_n`=0 at addr 200 with reads in flight -> all outputs 0 asynchronously; no `out_valid` after release; next full frame completes normally with `done`.
- Back-to-back frames: second frame's `en` rises in the `done` cycle -> second frame outputs 512 words with exactly one `out_last` and one `done`.
